controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 clk  input  1  sole clock; flag register updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (low clears flag register immediately).
REQ-003 instr  input  20 (bits 31:12)  cond=[31:28], op=[27:26], funct=[25:20], rd=[15:12].
REQ-004 ALUFlags  input  4  ALU result flags {N,Z,C,V} (bit3..bit0).
REQ-005 regSrc  output  2  register-file read-address select.
REQ-006 regWrite  output  1  register-file write enable (condition-gated).
REQ-007 immSrc  output  2  extender mode: 00 8-bit DP imm, 01 12-bit mem offset, 10 24-bit branch.
REQ-008 ALUSrc  output  1  1 = ALU operand B from immediate.
REQ-009 ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-010 memWrite  output  1  data-memory write enable (condition-gated).
REQ-011 memtoReg  output  1  1 = writeback from memory.
REQ-012 PCSrc  output  1  1 = PC loads result (condition-gated).

Function
REQ-013 All outputs combinational from instr, ALUFlags-derived stored flags; only state is 4-bit flag register {N,Z,C,V}.
REQ-014 Main decode: op=00,funct[5]=0 -> regW=1,ALUSrc=0,immSrc=00,regSrc=00,ALUOp=1.
REQ-015 op=00,funct[5]=1 -> regW=1,ALUSrc=1,immSrc=00,regSrc=00,ALUOp=1.
REQ-016 op=01,funct[0]=0 (STR) -> memW=1,regW=0,ALUSrc=1,immSrc=01,regSrc=10,ALUOp=0.
REQ-017 op=01,funct[0]=1 (LDR) -> memtoReg=1,regW=1,ALUSrc=1,immSrc=01,regSrc=00,ALUOp=0.
REQ-018 op=10 (B) -> branch=1,regW=0,ALUSrc=1,immSrc=10,regSrc=01,ALUOp=0; op=11 -> all control bits 0.
REQ-019 memtoReg, ALUSrc, immSrc, regSrc ungated by condition; all don't-care fields drive 0.
REQ-020 ALU decode, ALUOp=1: cmd=funct[4:1]: 0100->00, 0010->01, 0000->10, 1100->11, other->00; ALUOp=0 -> 00.
REQ-021 FlagW[1] (N,Z) = ALUOp & funct[0]; FlagW[0] (C,V) = ALUOp & funct[0] & (ALUControl is 00 or 01).
REQ-022 PCS = branch | (regW & rd==1111).
REQ-023 CondEx by cond: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !(C&!Z); 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 !(!Z&(N==V)); 1110 1; 1111 0.
REQ-024 CondEx uses stored flags, not ALUFlags of current instruction.
REQ-025 PCSrc=PCS&CondEx; regWrite=regW&CondEx; memWrite=memW&CondEx.
REQ-026 On rising clk: flags[3:2]<=ALUFlags[3:2] if FlagW[1]&CondEx; flags[1:0]<=ALUFlags[1:0] if FlagW[0]&CondEx; else hold.
REQ-027 Flags written at an edge affect CondEx from that edge onward (one-cycle visibility latency).

Reset
REQ-028 reset low asynchronously clears flags to 0000 and holds them while low; flag writes ignored during reset.
REQ-029 During reset outputs remain combinational, evaluated with flags=0000; reset mid-sequence discards all prior flags.

Configuration
REQ-030 Macro CONTROLLER_CMP_EN defined: DP cmd 1010 (CMP) -> ALUControl=01, FlagW=11 regardless of funct[0], regWrite forced 0.
REQ-031 Macro undefined: cmd 1010 treated as unsupported per REQ-020/021 (ALUControl=00, normal regW).

Verification
REQ-032 reset=1, instr=0xE0821 (ADD R1,R2,R3) -> regWrite=1, ALUSrc=0, ALUControl=00, regSrc=00, memWrite=0, PCSrc=0.
REQ-033 instr=0xE5902 (LDR) -> memtoReg=1, regWrite=1, ALUSrc=1, immSrc=01; instr=0xE5802 (STR) -> memWrite=1, regWrite=0, regSrc=10.
REQ-034 instr=0xE2500 (SUBS #1), ALUFlags=0100, one clk edge, then instr=0x0A000 (BEQ) -> PCSrc=1, immSrc=10, regSrc=01.
REQ-035 Same BEQ after reset pulse low -> flags 0000 -> PCSrc=0; instr=0x1A000 (BNE) -> PCSrc=1.
REQ-036 instr=0xE082F (ADD R15) -> PCSrc=1, regWrite=1; instr=0xF0821 (cond 1111) -> regWrite=0, PCSrc=0.

Source files
------------

// File: rtl/controller.sv
// controller: single-cycle instruction decoder with condition-gated writes and an NZCV flag register.
// Defining CONTROLLER_CMP_EN adds the CMP data-processing command (cmd 1010).
module controller (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] instr,
  input  logic [3:0]   ALUFlags,
  output logic [1:0]   regSrc,
  output logic         regWrite,
  output logic [1:0]   immSrc,
  output logic         ALUSrc,
  output logic [1:0]   ALUControl,
  output logic         memWrite,
  output logic         memtoReg,
  output logic         PCSrc
);

  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_cmd;
  logic [3:0] w_rd;
  logic       w_unused_rn;

  logic       w_branch;
  logic       w_regw;
  logic       w_memw;
  logic       w_aluop;
  logic       w_cmp;
  logic       w_regw_eff;
  logic [1:0] w_flagw;
  logic       w_pcs;
  logic       w_cond_ex;
  logic       w_n, w_z, w_c, w_v;

  logic [3:0] r_flags;

  assign w_cond      = instr[31:28];
  assign w_op        = instr[27:26];
  assign w_funct     = instr[25:20];
  assign w_cmd       = w_funct[4:1];
  assign w_rd        = instr[15:12];
  assign w_unused_rn = ^instr[19:16];

  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Main decoder: datapath steering and raw (ungated) write intents per opcode class
  always_comb begin
    w_branch = 1'b0;
    w_regw   = 1'b0;
    w_memw   = 1'b0;
    w_aluop  = 1'b0;
    memtoReg = 1'b0;
    ALUSrc   = 1'b0;
    immSrc   = 2'b00;
    regSrc   = 2'b00;
    case (w_op)
      2'b00: begin
        w_regw  = 1'b1;
        ALUSrc  = w_funct[5];
        w_aluop = 1'b1;
      end
      2'b01: begin
        ALUSrc = 1'b1;
        immSrc = 2'b01;
        if (w_funct[0]) begin
          memtoReg = 1'b1;
          w_regw   = 1'b1;
        end else begin
          w_memw = 1'b1;
          regSrc = 2'b10;
        end
      end
      2'b10: begin
        w_branch = 1'b1;
        ALUSrc   = 1'b1;
        immSrc   = 2'b10;
        regSrc   = 2'b01;
      end
      default: begin
        w_branch = 1'b0;
      end
    endcase
  end

  // ALU decoder: operation select and which flag groups the instruction may update
  always_comb begin
    ALUControl = 2'b00;
    w_flagw    = 2'b00;
    w_cmp      = 1'b0;
    if (w_aluop) begin
      case (w_cmd)
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
`ifdef CONTROLLER_CMP_EN
        4'b1010: begin
          ALUControl = 2'b01;
          w_cmp      = 1'b1;
        end
`endif
        default: ALUControl = 2'b00;
      endcase
      // C and V only carry meaning for arithmetic (ADD/SUB) results
      w_flagw[1] = w_funct[0] | w_cmp;
      w_flagw[0] = (w_funct[0] | w_cmp) & ~ALUControl[1];
    end else begin
      ALUControl = 2'b00;
      w_flagw    = 2'b00;
    end
  end

  // Condition check against the stored flags
  always_comb begin
    w_cond_ex = 1'b0;
    case (w_cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~(w_c & ~w_z);
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = ~(~w_z & (w_n == w_v));
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  assign w_regw_eff = w_regw & ~w_cmp;
  assign w_pcs      = w_branch | (w_regw_eff & (w_rd == 4'b1111));
  assign PCSrc      = w_pcs & w_cond_ex;
  assign regWrite   = w_regw_eff & w_cond_ex;
  assign memWrite   = w_memw & w_cond_ex;

  // Flag register: N/Z and C/V groups update independently when the instruction executes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else begin
      if (w_flagw[1] & w_cond_ex) r_flags[3:2] <= ALUFlags[3:2];
      if (w_flagw[0] & w_cond_ex) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: scoreboarded expected output vectors per scenario.
module tb_controller;
  logic         clk;
  logic         reset;
  logic [31:12] instr;
  logic [3:0]   ALUFlags;
  logic [1:0]   regSrc, immSrc, ALUControl;
  logic         regWrite, ALUSrc, memWrite, memtoReg, PCSrc;
  logic [10:0]  obs;

  typedef struct { string name; logic [19:0] ins; logic [3:0] fl; logic [10:0] exp; } step_t;
  typedef struct { string name; logic [10:0] exp; } sb_t;

  sb_t sb[$];
  int  n_total = 0;
  int  n_pass  = 0;

  // {regSrc, regWrite, immSrc, ALUSrc, ALUControl, memWrite, memtoReg, PCSrc}
  localparam logic [10:0] V_ADD     = 11'b00_1_00_0_00_0_0_0;
  localparam logic [10:0] V_ADD15   = 11'b00_1_00_0_00_0_0_1;
  localparam logic [10:0] V_SUBI    = 11'b00_1_00_1_01_0_0_0;
  localparam logic [10:0] V_SUBI_NX = 11'b00_0_00_1_01_0_0_0;
  localparam logic [10:0] V_AND     = 11'b00_1_00_0_10_0_0_0;
  localparam logic [10:0] V_ORR     = 11'b00_1_00_0_11_0_0_0;
  localparam logic [10:0] V_LDR     = 11'b00_1_01_1_00_0_1_0;
  localparam logic [10:0] V_STR     = 11'b10_0_01_1_00_1_0_0;
  localparam logic [10:0] V_STR_NX  = 11'b10_0_01_1_00_0_0_0;
  localparam logic [10:0] V_B1      = 11'b01_0_10_1_00_0_0_1;
  localparam logic [10:0] V_B0      = 11'b01_0_10_1_00_0_0_0;
  localparam logic [10:0] V_ZERO    = 11'b00_0_00_0_00_0_0_0;
`ifdef CONTROLLER_CMP_EN
  localparam logic [10:0] V_CMP     = 11'b00_0_00_0_01_0_0_0;
  localparam logic [10:0] V_CMP_BEQ = V_B1;
`else
  localparam logic [10:0] V_CMP     = V_ADD;
  localparam logic [10:0] V_CMP_BEQ = V_B0;
`endif

  controller dut (
    .clk(clk), .reset(reset), .instr(instr), .ALUFlags(ALUFlags),
    .regSrc(regSrc), .regWrite(regWrite), .immSrc(immSrc), .ALUSrc(ALUSrc),
    .ALUControl(ALUControl), .memWrite(memWrite), .memtoReg(memtoReg), .PCSrc(PCSrc)
  );

  assign obs = {regSrc, regWrite, immSrc, ALUSrc, ALUControl, memWrite, memtoReg, PCSrc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input string name, input logic [19:0] ins, input logic [3:0] fl,
                       input logic [10:0] exp);
    @(negedge clk);
    instr    = ins;
    ALUFlags = fl;
    sb.push_back('{name, exp});
  endtask

  task automatic test_reset();
    step_t t[$];
    sb_t   e;
    t.push_back('{"rst_add",  20'hE0821, 4'h0, V_ADD});
    t.push_back('{"rst_bne",  20'h1A000, 4'h4, V_B1});
    t.push_back('{"rst_beq",  20'h0A000, 4'h4, V_B0});
    t.push_back('{"rst_subs", 20'hE2500, 4'h4, V_SUBI});
    t.push_back('{"rst_beq2", 20'h0A000, 4'h4, V_B0});
    for (int i = 0; i < t.size(); i++) begin
      drive(t[i].name, t[i].ins, t[i].fl, t[i].exp);
      #1;
      e = sb.pop_front();
      n_total++;
      if (obs !== e.exp) $display("FAIL %s: observed %b expected %b", e.name, obs, e.exp);
      else n_pass++;
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_decode();
    step_t t[$];
    sb_t   e;
    t.push_back('{"add",    20'hE0821, 4'h0, V_ADD});
    t.push_back('{"add_r15",20'hE082F, 4'h0, V_ADD15});
    t.push_back('{"sub_imm",20'hE2400, 4'h0, V_SUBI});
    t.push_back('{"and",    20'hE0001, 4'h0, V_AND});
    t.push_back('{"orr",    20'hE1801, 4'h0, V_ORR});
    t.push_back('{"unsup",  20'hE0E01, 4'h0, V_ADD});
    t.push_back('{"ldr",    20'hE5902, 4'h0, V_LDR});
    t.push_back('{"str",    20'hE5802, 4'h0, V_STR});
    t.push_back('{"b_al",   20'hEA000, 4'h0, V_B1});
    t.push_back('{"op11",   20'hEC000, 4'h0, V_ZERO});
    t.push_back('{"nv_add", 20'hF0821, 4'h0, V_ZERO});
    t.push_back('{"nv_str", 20'hF5802, 4'h0, V_STR_NX});
    t.push_back('{"cmp",    20'hE1401, 4'h0, V_CMP});
    for (int i = 0; i < t.size(); i++) begin
      drive(t[i].name, t[i].ins, t[i].fl, t[i].exp);
      #1;
      e = sb.pop_front();
      n_total++;
      if (obs !== e.exp) $display("FAIL %s: observed %b expected %b", e.name, obs, e.exp);
      else n_pass++;
    end
  endtask

  task automatic test_flags();
    step_t t[$];
    sb_t   e;
    t.push_back('{"beq_pre",   20'h0A000, 4'h4, V_B0});
    t.push_back('{"subs",      20'hE2500, 4'h4, V_SUBI});
    t.push_back('{"beq_taken", 20'h0A000, 4'h0, V_B1});
    t.push_back('{"bne_not",   20'h1A000, 4'h0, V_B0});
    t.push_back('{"ands",      20'hE0101, 4'hB, V_AND});
    t.push_back('{"bmi",       20'h4A000, 4'h0, V_B1});
    t.push_back('{"bcs_hold",  20'h2A000, 4'h0, V_B0});
    t.push_back('{"bvs_hold",  20'h6A000, 4'h0, V_B0});
    t.push_back('{"beq_clr",   20'h0A000, 4'h0, V_B0});
    t.push_back('{"adds",      20'hE0901, 4'h3, V_ADD});
    t.push_back('{"bhi",       20'h8A000, 4'h0, V_B1});
    t.push_back('{"bge",       20'hAA000, 4'h0, V_B0});
    t.push_back('{"blt",       20'hBA000, 4'h0, V_B1});
    t.push_back('{"add_nos",   20'hE0821, 4'hF, V_ADD});
    t.push_back('{"bpl",       20'h5A000, 4'h0, V_B1});
    t.push_back('{"bne",       20'h1A000, 4'h0, V_B1});
    t.push_back('{"subs_eq",   20'h02500, 4'h4, V_SUBI_NX});
    t.push_back('{"beq_still", 20'h0A000, 4'h0, V_B0});
    t.push_back('{"bls",       20'h9A000, 4'h0, V_B0});
    t.push_back('{"ble",       20'hDA000, 4'h0, V_B1});
    t.push_back('{"bgt",       20'hCA000, 4'h0, V_B0});
    t.push_back('{"bvc",       20'h7A000, 4'h0, V_B0});
    t.push_back('{"bcc",       20'h3A000, 4'h0, V_B0});
    t.push_back('{"bnv",       20'hFA000, 4'h0, V_B0});
    t.push_back('{"subs_cv",   20'hE2500, 4'h6, V_SUBI});
    t.push_back('{"bcs2",      20'h2A000, 4'h0, V_B1});
    t.push_back('{"bvc2",      20'h7A000, 4'h0, V_B1});
    t.push_back('{"bls2",      20'h9A000, 4'h0, V_B1});
    t.push_back('{"bmi2",      20'h4A000, 4'h0, V_B0});
    t.push_back('{"beq2",      20'h0A000, 4'h0, V_B1});
    for (int i = 0; i < t.size(); i++) begin
      drive(t[i].name, t[i].ins, t[i].fl, t[i].exp);
      #1;
      e = sb.pop_front();
      n_total++;
      if (obs !== e.exp) $display("FAIL %s: observed %b expected %b", e.name, obs, e.exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    step_t t[$];
    sb_t   e;
    // Reset drops between clock edges with Z set; the branch must fall through at once
    #2;
    reset = 1'b0;
    sb.push_back('{"mid_async_beq", V_B0});
    #1;
    e = sb.pop_front();
    n_total++;
    if (obs !== e.exp) $display("FAIL %s: observed %b expected %b", e.name, obs, e.exp);
    else n_pass++;
    t.push_back('{"mid_subs",  20'hE2500, 4'h4, V_SUBI});
    t.push_back('{"mid_beq_l", 20'h0A000, 4'h4, V_B0});
    for (int i = 0; i < t.size(); i++) begin
      drive(t[i].name, t[i].ins, t[i].fl, t[i].exp);
      #1;
      e = sb.pop_front();
      n_total++;
      if (obs !== e.exp) $display("FAIL %s: observed %b expected %b", e.name, obs, e.exp);
      else n_pass++;
    end
    @(negedge clk);
    reset = 1'b1;
    t.delete();
    t.push_back('{"post_beq", 20'h0A000, 4'h0, V_B0});
    t.push_back('{"post_bne", 20'h1A000, 4'h0, V_B1});
    t.push_back('{"post_bgt", 20'hCA000, 4'h0, V_B1});
    t.push_back('{"post_ble", 20'hDA000, 4'h0, V_B0});
    for (int i = 0; i < t.size(); i++) begin
      drive(t[i].name, t[i].ins, t[i].fl, t[i].exp);
      #1;
      e = sb.pop_front();
      n_total++;
      if (obs !== e.exp) $display("FAIL %s: observed %b expected %b", e.name, obs, e.exp);
      else n_pass++;
    end
  endtask

  task automatic test_cmp();
    step_t t[$];
    sb_t   e;
    t.push_back('{"cmp_z",   20'hE1401, 4'h4, V_CMP});
    t.push_back('{"cmp_beq", 20'h0A000, 4'h0, V_CMP_BEQ});
    for (int i = 0; i < t.size(); i++) begin
      drive(t[i].name, t[i].ins, t[i].fl, t[i].exp);
      #1;
      e = sb.pop_front();
      n_total++;
      if (obs !== e.exp) $display("FAIL %s: observed %b expected %b", e.name, obs, e.exp);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    step_t t[$];
    sb_t   e;
    t.push_back('{"b2b_subs_z",  20'hE2500, 4'h4, V_SUBI});
    t.push_back('{"b2b_subs_nz", 20'hE2500, 4'h0, V_SUBI});
    t.push_back('{"b2b_beq0",    20'h0A000, 4'h4, V_B0});
    t.push_back('{"b2b_subs_z2", 20'hE2500, 4'h4, V_SUBI});
    t.push_back('{"b2b_beq1",    20'h0A000, 4'h0, V_B1});
    t.push_back('{"b2b_ldr",     20'hE5902, 4'h0, V_LDR});
    t.push_back('{"b2b_str",     20'hE5802, 4'h0, V_STR});
    for (int i = 0; i < t.size(); i++) begin
      drive(t[i].name, t[i].ins, t[i].fl, t[i].exp);
      #1;
      e = sb.pop_front();
      n_total++;
      if (obs !== e.exp) $display("FAIL %s: observed %b expected %b", e.name, obs, e.exp);
      else n_pass++;
    end
  endtask

  initial begin
    reset    = 1'b0;
    instr    = 20'h00000;
    ALUFlags = 4'h0;
    test_reset();
    test_decode();
    test_flags();
    test_reset_mid();
    test_cmp();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
